pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Pipelined successor of the single-cycle MIPS main control: decodes opcode/funct in ID and
//  stages the control bundle through ID/EX, EX/MEM and MEM/WB registers. Adds load-use and RAW
//  hazard detection, branch/jump flush, a dcache-stall freeze, and optional forwarding selects.
//  Sits between the IF/ID register and the 5-stage datapath.
// PARAMETERS
//  OP_W     6  opcode/funct width
//  REG_AW   5  register address width
//  ALUOP_W  2  ALUOp width to ALU control
// PORTS
//  clk              in   1        clock
//  rst              in   1        reset, asynchronous, active-high
//  id_op            in   OP_W     opcode of instruction in ID
//  id_funct         in   OP_W     funct of instruction in ID
//  id_rs,id_rt,id_rd in  REG_AW   source/dest fields in ID
//  ex_zero          in   1        ALU zero flag in EX
//  mem_stall        in   1        dcache busy; freeze pipeline
//  pc_write         out  1        PC update enable
//  ifid_write       out  1        IF/ID update enable
//  ifid_flush       out  1        IF/ID -> NOP
//  id_jump,id_jal,id_jr out 1     jump redirects resolved in ID
//  ex_regdst,ex_alusrc out 1      EX controls
//  ex_aluop         out  ALUOP_W  EX ALUOp
//  ex_branch_taken  out  1        ex_branch & ex_zero
//  mem_memread,mem_memwrite out 1 MEM controls
//  wb_regwrite,wb_memtoreg out 1  WB controls
//  wb_wreg          out  REG_AW   WB destination register
//  fwd_a,fwd_b      out  2        ALU operand selects (CTRL_FORWARD_EN only)
// BEHAVIOUR
//  - Decode (comb., ID): R {RegDst,RegWrite,ALUOp=10}; lw {ALUsrc,MemtoReg,RegWrite,MemRead,00};
//    sw {ALUsrc,MemWrite,00}; beq {Branch,01}; j {Jump}; jal {Jump,Jal,RegWrite,wreg=31};
//    R with funct 001000 = jr {Jr, no RegWrite}. Unknown opcode -> all-zero bundle (NOP).
//  - wreg: RegDst ? rd : (Jal ? 31 : rt). wreg==0 never counts as a hazard/forward source.
//  - Latency: ex_* 1 cycle after ID, mem_* 2, wb_* 3. Outputs are register-driven except
//    pc_write, ifid_*, id_*, ex_branch_taken, fwd_*.
//  - Reset: all staged regs 0 (bubble) -> every ex_/mem_/wb_ output 0; pc_write=ifid_write=1
//    with no hazard. Reset mid-flight discards all in-flight control.
//  - Priority each cycle: mem_stall > ex_branch_taken > hazard stall > ID jump.
//    mem_stall: all staged regs hold, pc_write=ifid_write=0, ifid_flush=0; a pending taken
//      branch is held and acted on the cycle mem_stall drops.
//    ex_branch_taken: ifid_flush=1, ID/EX loads bubble, pc_write=1 (overrides any stall).
//    hazard stall: pc_write=ifid_write=0, ID/EX loads bubble, later stages advance.
//    id_jump/id_jr (no stall): ifid_flush=1, ID/EX takes jump bundle.
//  - Hazards (rs always used; rt used by R/sw/beq):
//    load-use: ex_memread & ex_wreg matches a used source -> 1-cycle stall.
//    jr: stall while EX or MEM regwrite targets id_rs (no ID forwarding).
//    RF writes in first half-cycle: WB never causes a stall.
// CONFIGURATION
//  CTRL_FORWARD_EN defined: fwd_a/fwd_b per operand = 10 if MEM regwrite & wreg==ex src,
//    else 01 if WB match, else 00; only load-use and jr stalls occur.
//  Undefined: fwd_a=fwd_b=00 constant; any EX or MEM regwrite matching a used ID source stalls
//    (up to 2 cycles).
// STRUCTURE
//  ctrl_pkg: opcode/funct localparams, ALUOp codes, ctrl_bundle_t typedef, NOP bundle constant.
//  Sub-module hazard_unit: stall/flush/forward logic; top holds decode and stage registers.
// TESTING
//  1. R add $3 then lw $4 -> ex_aluop 10,regdst 1 at T+1; lw wb_memtoreg=1,wb_wreg=4 at T+3.
//  2. lw $2 then add $5,$2,$1 -> pc_write=ifid_write=0 one cycle, ex_* zero; fwd_a=01 next.
//  3. beq with ex_zero=1 during lw-use stall -> ifid_flush=1, pc_write=1, bubble in EX.
//  4. jal -> id_jump=id_jal=1, ifid_flush=1; wb_wreg=31,wb_regwrite=1 three cycles later.
//  5. mem_stall high 3 cycles mid-stream -> all staged outputs frozen; resume unchanged.
//  6. Undefined CTRL_FORWARD_EN: add $2; add $4,$2,$2 -> 2-cycle stall; defined: fwd_a=fwd_b=10.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared decode constants and control-bundle types for the pipelined MIPS control unit.
// Holds opcode/funct codes, ALUOp and forwarding-select encodings, and the ID decoder.
package ctrl_pkg;

    localparam int unsigned CTRL_OP_W    = 6;
    localparam int unsigned CTRL_REG_AW  = 5;
    localparam int unsigned CTRL_ALUOP_W = 2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Full decoded bundle as seen in ID; use_rt marks instructions that read rt.
    typedef struct packed {
        logic                    regdst;
        logic                    alusrc;
        logic [CTRL_ALUOP_W-1:0] aluop;
        logic                    branch;
        logic                    memread;
        logic                    memwrite;
        logic                    regwrite;
        logic                    memtoreg;
        logic                    jump;
        logic                    jal;
        logic                    jr;
        logic                    use_rt;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NOP = '0;

    typedef struct packed {
        logic                    regdst;
        logic                    alusrc;
        logic [CTRL_ALUOP_W-1:0] aluop;
        logic                    branch;
        logic                    memread;
        logic                    memwrite;
        logic                    regwrite;
        logic                    memtoreg;
    } ex_ctrl_t;

    typedef struct packed {
        logic memread;
        logic memwrite;
        logic regwrite;
        logic memtoreg;
    } mem_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    function automatic ctrl_bundle_t decode(input logic [5:0] op, input logic [5:0] funct);
        ctrl_bundle_t c;
        c = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                c.use_rt = 1'b1;
                if (funct == FUNCT_JR) begin
                    c.jr = 1'b1;
                end else begin
                    c.regdst   = 1'b1;
                    c.regwrite = 1'b1;
                    c.aluop    = ALUOP_FUNCT;
                end
            end
            OP_LW: begin
                c.alusrc   = 1'b1;
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
                c.memread  = 1'b1;
                c.aluop    = ALUOP_ADD;
            end
            OP_SW: begin
                c.alusrc   = 1'b1;
                c.memwrite = 1'b1;
                c.aluop    = ALUOP_ADD;
                c.use_rt   = 1'b1;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.aluop  = ALUOP_SUB;
                c.use_rt = 1'b1;
            end
            OP_J: c.jump = 1'b1;
            OP_JAL: begin
                c.jump     = 1'b1;
                c.jal      = 1'b1;
                c.regwrite = 1'b1;
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Stall, flush and forwarding-select logic for the pipelined control unit.
// CTRL_FORWARD_EN enables EX operand forwarding selects and limits stalls to load-use and jr.
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = CTRL_REG_AW
) (
    input  logic              mem_stall,
    input  logic              branch_taken,
    input  logic              id_is_jump,
    input  logic              id_is_jr,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_wreg,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              jump_go,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    // $zero is never a real producer.
    function automatic logic hit(input logic we, input logic [REG_AW-1:0] wreg,
                                 input logic [REG_AW-1:0] src);
        return we && (wreg != '0) && (wreg == src);
    endfunction

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic load_use, stall;

    assign ex_hit_rs  = hit(ex_regwrite, ex_wreg, id_rs);
    assign ex_hit_rt  = id_use_rt && hit(ex_regwrite, ex_wreg, id_rt);
    assign mem_hit_rs = hit(mem_regwrite, mem_wreg, id_rs);
    assign mem_hit_rt = id_use_rt && hit(mem_regwrite, mem_wreg, id_rt);
    assign load_use   = ex_memread && (ex_hit_rs || ex_hit_rt);

`ifdef CTRL_FORWARD_EN
    // jr reads rs in ID, where nothing is forwarded.
    assign stall = load_use || (id_is_jr && (ex_hit_rs || mem_hit_rs));

    always_comb begin
        fwd_a = FWD_NONE;
        fwd_b = FWD_NONE;
        if (hit(mem_regwrite, mem_wreg, ex_rs)) begin
            fwd_a = FWD_MEM;
        end else if (hit(wb_regwrite, wb_wreg, ex_rs)) begin
            fwd_a = FWD_WB;
        end
        if (hit(mem_regwrite, mem_wreg, ex_rt)) begin
            fwd_b = FWD_MEM;
        end else if (hit(wb_regwrite, wb_wreg, ex_rt)) begin
            fwd_b = FWD_WB;
        end
    end
`else
    assign stall = load_use || ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt;
    assign fwd_a = FWD_NONE;
    assign fwd_b = FWD_NONE;

    logic unused_fwd;
    assign unused_fwd = ^{ex_rs, ex_rt, wb_regwrite, wb_wreg, id_is_jr};
`endif

    assign jump_go = !mem_stall && !branch_taken && !stall;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (mem_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_is_jump) begin
            ifid_flush = 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS main control: ID decode plus ID/EX, EX/MEM and MEM/WB control registers.
// Optional forwarding selects are built when CTRL_FORWARD_EN is defined.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = CTRL_OP_W,
    parameter int unsigned REG_AW  = CTRL_REG_AW,
    parameter int unsigned ALUOP_W = CTRL_ALUOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    id_op,
    input  logic [OP_W-1:0]    id_funct,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               ex_zero,
    input  logic               mem_stall,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               id_jump,
    output logic               id_jal,
    output logic               id_jr,
    output logic               ex_regdst,
    output logic               ex_alusrc,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_branch_taken,
    output logic               mem_memread,
    output logic               mem_memwrite,
    output logic               wb_regwrite,
    output logic               wb_memtoreg,
    output logic [REG_AW-1:0]  wb_wreg,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
);

    ctrl_bundle_t      id_ctrl;
    logic [REG_AW-1:0] id_wreg;

    ex_ctrl_t          ex_d, ex_q;
    logic [REG_AW-1:0] ex_wreg_d, ex_wreg_q;
    logic [REG_AW-1:0] ex_rs_d, ex_rs_q;
    logic [REG_AW-1:0] ex_rt_d, ex_rt_q;
    mem_ctrl_t         mem_q;
    logic [REG_AW-1:0] mem_wreg_q;
    wb_ctrl_t          wb_q;
    logic [REG_AW-1:0] wb_wreg_q;

    logic idex_bubble, jump_go;

    assign id_ctrl = decode(id_op, id_funct);
    // jal links into $ra, the all-ones register.
    assign id_wreg = id_ctrl.regdst ? id_rd : (id_ctrl.jal ? '1 : id_rt);

    assign ex_branch_taken = ex_q.branch && ex_zero;

    hazard_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .mem_stall    (mem_stall),
        .branch_taken (ex_branch_taken),
        .id_is_jump   (id_ctrl.jump || id_ctrl.jr),
        .id_is_jr     (id_ctrl.jr),
        .id_use_rt    (id_ctrl.use_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_regwrite  (ex_q.regwrite),
        .ex_memread   (ex_q.memread),
        .ex_wreg      (ex_wreg_q),
        .ex_rs        (ex_rs_q),
        .ex_rt        (ex_rt_q),
        .mem_regwrite (mem_q.regwrite),
        .mem_wreg     (mem_wreg_q),
        .wb_regwrite  (wb_q.regwrite),
        .wb_wreg      (wb_wreg_q),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .jump_go      (jump_go),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    // Redirects are only reported when they actually take effect this cycle.
    assign id_jump = id_ctrl.jump && jump_go;
    assign id_jal  = id_ctrl.jal && jump_go;
    assign id_jr   = id_ctrl.jr && jump_go;

    always_comb begin
        ex_d      = '0;
        ex_wreg_d = '0;
        ex_rs_d   = '0;
        ex_rt_d   = '0;
        if (!idex_bubble) begin
            ex_d.regdst   = id_ctrl.regdst;
            ex_d.alusrc   = id_ctrl.alusrc;
            ex_d.aluop    = id_ctrl.aluop;
            ex_d.branch   = id_ctrl.branch;
            ex_d.memread  = id_ctrl.memread;
            ex_d.memwrite = id_ctrl.memwrite;
            ex_d.regwrite = id_ctrl.regwrite;
            ex_d.memtoreg = id_ctrl.memtoreg;
            ex_wreg_d     = id_wreg;
            ex_rs_d       = id_rs;
            ex_rt_d       = id_rt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            ex_wreg_q  <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            mem_q      <= '0;
            mem_wreg_q <= '0;
            wb_q       <= '0;
            wb_wreg_q  <= '0;
        end else if (!mem_stall) begin
            ex_q       <= ex_d;
            ex_wreg_q  <= ex_wreg_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            mem_q      <= '{memread:  ex_q.memread,  memwrite: ex_q.memwrite,
                            regwrite: ex_q.regwrite, memtoreg: ex_q.memtoreg};
            mem_wreg_q <= ex_wreg_q;
            wb_q       <= '{regwrite: mem_q.regwrite, memtoreg: mem_q.memtoreg};
            wb_wreg_q  <= mem_wreg_q;
        end
    end

    assign ex_regdst    = ex_q.regdst;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_aluop     = ex_q.aluop;
    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_wreg      = wb_wreg_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: the bench acts as IF/ID, tracks instructions per stage
// and pushes the expected outputs for every cycle; a monitor pops and compares at negedge.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] id_op = '0, id_funct = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       ex_zero = 1'b0, mem_stall = 1'b0;
    logic       pc_write, ifid_write, ifid_flush, id_jump, id_jal, id_jr;
    logic       ex_regdst, ex_alusrc, ex_branch_taken, mem_memread, mem_memwrite;
    logic       wb_regwrite, wb_memtoreg;
    logic [1:0] ex_aluop, fwd_a, fwd_b;
    logic [4:0] wb_wreg;

    always #5 clk = ~clk;

    pipe_ctrl_unit dut (
        .clk             (clk),
        .rst             (rst),
        .id_op           (id_op),
        .id_funct        (id_funct),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .ex_zero         (ex_zero),
        .mem_stall       (mem_stall),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .id_jump         (id_jump),
        .id_jal          (id_jal),
        .id_jr           (id_jr),
        .ex_regdst       (ex_regdst),
        .ex_alusrc       (ex_alusrc),
        .ex_aluop        (ex_aluop),
        .ex_branch_taken (ex_branch_taken),
        .mem_memread     (mem_memread),
        .mem_memwrite    (mem_memwrite),
        .wb_regwrite     (wb_regwrite),
        .wb_memtoreg     (wb_memtoreg),
        .wb_wreg         (wb_wreg),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b)
    );

    localparam int K_BUB = 0, K_R = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;
    localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_UNK = 8;

    typedef struct {
        int         k;
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rs, rt, rd;
    } ins_t;

    typedef struct packed {
        logic       pc_write, ifid_write, ifid_flush, id_jump, id_jal, id_jr;
        logic       ex_regdst, ex_alusrc;
        logic [1:0] ex_aluop;
        logic       ex_bt, mem_memread, mem_memwrite, wb_regwrite, wb_memtoreg;
        logic [4:0] wb_wreg;
        logic [1:0] fwd_a, fwd_b;
    } exp_t;

    exp_t sbq[$];
    ins_t dq[$];
    ins_t ex_s, mem_s, wb_s, id_s;
    int   vectors = 0;
    int   miscompares = 0;
    bit   done = 1'b0;

    function automatic ins_t make(int k, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        ins_t i;
        i.k = k; i.rs = rs; i.rt = rt; i.rd = rd;
        i.op = 6'd0;
        i.funct = 6'($urandom);
        case (k)
            K_R: begin
                case ($urandom_range(0, 3))
                    0: i.funct = 6'd32;
                    1: i.funct = 6'd34;
                    2: i.funct = 6'd36;
                    default: i.funct = 6'd42;
                endcase
            end
            K_JR:  i.funct = 6'd8;
            K_LW:  i.op = 6'd35;
            K_SW:  i.op = 6'd43;
            K_BEQ: i.op = 6'd4;
            K_J:   i.op = 6'd2;
            K_JAL: i.op = 6'd3;
            default: begin
                case ($urandom_range(0, 3))
                    0: i.op = 6'd8;
                    1: i.op = 6'd13;
                    2: i.op = 6'd5;
                    default: i.op = 6'd32;
                endcase
            end
        endcase
        return i;
    endfunction

    function automatic ins_t nop();
        ins_t i;
        i.k = K_R; i.op = '0; i.funct = '0; i.rs = '0; i.rt = '0; i.rd = '0;
        return i;
    endfunction

    function automatic ins_t bubble();
        ins_t i;
        i = nop();
        i.k = K_BUB;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        return make($urandom_range(1, 8), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                    5'($urandom_range(0, 4)));
    endfunction

    function automatic bit writes(ins_t i);
        return i.k == K_R || i.k == K_LW || i.k == K_JAL;
    endfunction

    function automatic logic [4:0] wreg_of(ins_t i);
        if (i.k == K_BUB) return 5'd0;
        if (i.k == K_R) return i.rd;
        if (i.k == K_JAL) return 5'd31;
        return i.rt;
    endfunction

    function automatic bit hits(ins_t s, logic [4:0] src);
        return writes(s) && wreg_of(s) != 5'd0 && wreg_of(s) == src;
    endfunction

    function automatic bit uses_rt(ins_t i);
        return i.k == K_R || i.k == K_JR || i.k == K_SW || i.k == K_BEQ;
    endfunction

    function automatic ins_t next_src();
        if (dq.size() > 0) return dq.pop_front();
        return rand_ins();
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive();
        int   burst = 0;
        bit   cur_rst, cur_stall, bt, ld, stall;
        bit   cur_zero = 1'b0;
        exp_t e;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk);
            #1;
            cur_rst = (cyc < 3) || (cyc == 800) || (cyc == 801);
            if (cyc >= 40 && cyc < 43) begin
                cur_stall = 1'b1;
            end else if (burst > 0) begin
                cur_stall = 1'b1;
                burst--;
            end else begin
                cur_stall = 1'b0;
                if ($urandom_range(0, 15) == 0) burst = $urandom_range(1, 4);
            end
            // ALU operands are frozen with the pipeline, so the zero flag is too.
            if (!cur_stall) cur_zero = 1'($urandom_range(0, 1));
            if (cur_rst) begin
                ex_s = bubble(); mem_s = bubble(); wb_s = bubble(); id_s = nop();
            end
            rst = cur_rst; mem_stall = cur_stall; ex_zero = cur_zero;
            id_op = id_s.op; id_funct = id_s.funct;
            id_rs = id_s.rs; id_rt = id_s.rt; id_rd = id_s.rd;

            bt = (ex_s.k == K_BEQ) && cur_zero;
            ld = (ex_s.k == K_LW) &&
                 (hits(ex_s, id_s.rs) || (uses_rt(id_s) && hits(ex_s, id_s.rt)));
`ifdef CTRL_FORWARD_EN
            stall = ld || (id_s.k == K_JR && (hits(ex_s, id_s.rs) || hits(mem_s, id_s.rs)));
`else
            stall = ld || hits(ex_s, id_s.rs) || hits(mem_s, id_s.rs) ||
                    (uses_rt(id_s) && (hits(ex_s, id_s.rt) || hits(mem_s, id_s.rt)));
`endif
            e = '0;
            if (!cur_stall) begin
                if (bt) begin
                    e.pc_write = 1; e.ifid_write = 1; e.ifid_flush = 1;
                end else if (!stall) begin
                    e.pc_write = 1; e.ifid_write = 1;
                    e.ifid_flush = id_s.k == K_J || id_s.k == K_JAL || id_s.k == K_JR;
                    e.id_jump = id_s.k == K_J || id_s.k == K_JAL;
                    e.id_jal = id_s.k == K_JAL;
                    e.id_jr = id_s.k == K_JR;
                end
            end
            e.ex_regdst = ex_s.k == K_R;
            e.ex_alusrc = ex_s.k == K_LW || ex_s.k == K_SW;
            e.ex_aluop = (ex_s.k == K_R) ? 2'd2 : ((ex_s.k == K_BEQ) ? 2'd1 : 2'd0);
            e.ex_bt = bt;
            e.mem_memread = mem_s.k == K_LW;
            e.mem_memwrite = mem_s.k == K_SW;
            e.wb_regwrite = writes(wb_s);
            e.wb_memtoreg = wb_s.k == K_LW;
            e.wb_wreg = wreg_of(wb_s);
`ifdef CTRL_FORWARD_EN
            e.fwd_a = hits(mem_s, ex_s.rs) ? 2'd2 : (hits(wb_s, ex_s.rs) ? 2'd1 : 2'd0);
            e.fwd_b = hits(mem_s, ex_s.rt) ? 2'd2 : (hits(wb_s, ex_s.rt) ? 2'd1 : 2'd0);
`endif
            sbq.push_back(e);

            if (!cur_rst && !cur_stall) begin
                wb_s = mem_s;
                mem_s = ex_s;
                ex_s = (bt || stall) ? bubble() : id_s;
                if (e.ifid_flush) id_s = nop();
                else if (e.ifid_write) id_s = next_src();
            end
        end
        @(posedge clk);
        #1;
        done = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        while (!(done && sbq.size() == 0)) begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                vectors++;
                chk("pc_write", 8'(pc_write), 8'(e.pc_write));
                chk("ifid_write", 8'(ifid_write), 8'(e.ifid_write));
                chk("ifid_flush", 8'(ifid_flush), 8'(e.ifid_flush));
                chk("id_jump", 8'(id_jump), 8'(e.id_jump));
                chk("id_jal", 8'(id_jal), 8'(e.id_jal));
                chk("id_jr", 8'(id_jr), 8'(e.id_jr));
                chk("ex_regdst", 8'(ex_regdst), 8'(e.ex_regdst));
                chk("ex_alusrc", 8'(ex_alusrc), 8'(e.ex_alusrc));
                chk("ex_aluop", 8'(ex_aluop), 8'(e.ex_aluop));
                chk("ex_branch_taken", 8'(ex_branch_taken), 8'(e.ex_bt));
                chk("mem_memread", 8'(mem_memread), 8'(e.mem_memread));
                chk("mem_memwrite", 8'(mem_memwrite), 8'(e.mem_memwrite));
                chk("wb_regwrite", 8'(wb_regwrite), 8'(e.wb_regwrite));
                chk("wb_memtoreg", 8'(wb_memtoreg), 8'(e.wb_memtoreg));
                chk("wb_wreg", 8'(wb_wreg), 8'(e.wb_wreg));
                chk("fwd_a", 8'(fwd_a), 8'(e.fwd_a));
                chk("fwd_b", 8'(fwd_b), 8'(e.fwd_b));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, %0d vectors popped", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        ex_s = bubble(); mem_s = bubble(); wb_s = bubble(); id_s = nop();
        // Directed prologue: R then lw, lw-use, jal link, back-to-back RAW, branch after lw.
        dq.push_back(make(K_R, 5'd1, 5'd2, 5'd3));
        dq.push_back(make(K_LW, 5'd1, 5'd4, 5'd0));
        dq.push_back(nop());
        dq.push_back(nop());
        dq.push_back(make(K_LW, 5'd1, 5'd2, 5'd0));
        dq.push_back(make(K_R, 5'd2, 5'd1, 5'd5));
        dq.push_back(nop());
        dq.push_back(make(K_JAL, 5'd3, 5'd4, 5'd1));
        dq.push_back(nop());
        dq.push_back(nop());
        dq.push_back(make(K_R, 5'd1, 5'd1, 5'd2));
        dq.push_back(make(K_R, 5'd2, 5'd2, 5'd4));
        dq.push_back(make(K_LW, 5'd1, 5'd2, 5'd0));
        dq.push_back(make(K_BEQ, 5'd1, 5'd1, 5'd0));
        dq.push_back(make(K_R, 5'd2, 5'd1, 5'd5));
        dq.push_back(make(K_JR, 5'd5, 5'd0, 5'd0));
        fork
            drive();
            monitor();
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
